// File: rtl/pack_stream.sv
// Sparse-to-dense lane packer: compacts masked lanes into N-word beats, flushing the residual on frame end.
// Latency: one cycle from accept to out_vld_r; full throughput with out_rdy held high.
// Backpressure: in_rdy drops while a held beat is stalled or a frame-end flush is pending.
// PACK_STREAM_ZERO_FILL_EN: zero unmasked output lanes on load and reset all data storage.
module pack_stream #(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [N-1:0][W-1:0] in_w,
  input  logic [N-1:0]        in_msk,
  input  logic                in_last,
  output logic                out_vld_r,
  input  logic                out_rdy,
  output logic [N-1:0][W-1:0] out_r,
  output logic [N-1:0]        out_msk_r,
  output logic                out_last_r
);

  localparam int IW = $clog2(2*N-1);
  localparam int CW = $clog2(2*N) + 1;
  localparam logic [CW-1:0] NC = CW'(N);
  localparam logic [N-1:0] ONES = '1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state, state_nxt;
  logic [N-2:0][W-1:0]   res_q, res_nxt;
  logic [CW-1:0]         res_cnt, cnt_nxt, c;
  logic [2*N-2:0][W-1:0] comb;
  logic                  ofree, acc, load, ld_last;
  logic [N-1:0][W-1:0]   ld_dat;
  logic [N-1:0]          ld_msk;

  assign ofree  = ~out_vld_r | out_rdy;
  assign in_rdy = ofree & (state == RUN);
  assign acc    = in_vld & in_rdy;

  // Residual occupies positions 0..res_cnt-1; masked input lanes append in order.
  always_comb begin
    comb = '0;
    for (int i = 0; i < N-1; i++) comb[i] = res_q[i];
    c = res_cnt;
    for (int j = 0; j < N; j++) begin
      if (in_msk[j]) begin
        comb[c[IW-1:0]] = in_w[j];
        c = c + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = res_cnt;
    res_nxt   = res_q;
    load      = 1'b0;
    ld_dat    = comb[N-1:0];
    ld_msk    = '0;
    ld_last   = 1'b0;
    if (state == RUN) begin
      if (acc) begin
        if (c > NC || (c == NC && !in_last)) begin
          load    = 1'b1;
          ld_msk  = ONES;
          res_nxt = comb[2*N-2:N];
          cnt_nxt = c - NC;
          if (in_last) state_nxt = FLUSH;
        end else if (!in_last) begin
          res_nxt = comb[N-2:0];
          cnt_nxt = c;
        end else begin
          load    = 1'b1;
          ld_msk  = ~(ONES << c);
          ld_last = 1'b1;
          cnt_nxt = '0;
        end
      end
    end else if (ofree) begin
      load      = 1'b1;
      ld_dat    = {{W{1'b0}}, res_q};
      ld_msk    = ~(ONES << res_cnt);
      ld_last   = 1'b1;
      cnt_nxt   = '0;
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      res_cnt    <= '0;
      out_vld_r  <= 1'b0;
      out_msk_r  <= '0;
      out_last_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      res_cnt <= cnt_nxt;
      if (load) begin
        out_vld_r  <= 1'b1;
        out_msk_r  <= ld_msk;
        out_last_r <= ld_last;
      end else if (ofree) begin
        out_vld_r  <= 1'b0;
      end
    end
  end

`ifdef PACK_STREAM_ZERO_FILL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      out_r <= '0;
    end else begin
      res_q <= res_nxt;
      if (load) begin
        for (int i = 0; i < N; i++) out_r[i] <= ld_msk[i] ? ld_dat[i] : '0;
      end
    end
  end
`else
  // Only lanes inside the new mask are written; the rest keep stale data.
  always_ff @(posedge clk) begin
    res_q <= res_nxt;
    for (int i = 0; i < N; i++) begin
      if (load && ld_msk[i]) out_r[i] <= ld_dat[i];
    end
  end
`endif

endmodule

// File: tb/tb_pack_stream.sv
// Scoreboarded bench for pack_stream at N=4, W=8 with directed beats.
module tb_pack_stream;
  localparam int N = 4;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_vld;
  logic                in_rdy;
  logic [N-1:0][W-1:0] in_w;
  logic [N-1:0]        in_msk;
  logic                in_last;
  logic                out_vld_r;
  logic                out_rdy;
  logic [N-1:0][W-1:0] out_r;
  logic [N-1:0]        out_msk_r;
  logic                out_last_r;

  pack_stream #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_w(in_w), .in_msk(in_msk), .in_last(in_last),
    .out_vld_r(out_vld_r), .out_rdy(out_rdy), .out_r(out_r),
    .out_msk_r(out_msk_r), .out_last_r(out_last_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  m;
    logic        l;
  } beat_t;

  beat_t sb[$];
  int tests = 0;
  int fails = 0;
  int n_push = 0;
  int n_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] m, input logic l);
    beat_t b;
    b.d = d; b.m = m; b.l = l;
    sb.push_back(b);
    n_push++;
  endtask

  task automatic send(input logic [3:0] m, input logic [31:0] d, input logic l);
    int t;
    in_vld = 1'b1; in_msk = m; in_w = d; in_last = l;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_rdy && t < 50);
    if (!in_rdy) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_rdy stayed 0 for %0d cycles", t);
    end
    @(posedge clk); #1;
    in_vld = 1'b0; in_msk = '0; in_last = 1'b0; in_w = '0;
  endtask

  // Monitor: a beat retires at the next edge when valid and ready are both high.
  initial begin
    beat_t b;
    logic [31:0] lm;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_vld_r === 1'b1 && out_rdy === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'(out_r), 32'hxxxxxxxx);
        end else begin
          b = sb.pop_front();
          n_pop++;
          lm = '0;
          for (int i = 0; i < N; i++) if (b.m[i]) lm[i*W +: W] = '1;
`ifdef PACK_STREAM_ZERO_FILL_EN
          chk("beat_data", 32'(out_r), b.d);
`else
          chk("beat_data", 32'(out_r) & lm, b.d & lm);
`endif
          chk("beat_msk", 32'(out_msk_r), 32'(b.m));
          chk("beat_last", 32'(out_last_r), 32'(b.l));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; in_vld = 1'b0; in_w = '0; in_msk = '0; in_last = 1'b0; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", 32'(out_vld_r), 0);
    chk("rst_out_msk", 32'(out_msk_r), 0);
    chk("rst_out_last", 32'(out_last_r), 0);
    chk("rst_in_rdy", 32'(in_rdy), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Sparse accumulation: two half beats merge into one dense beat.
    send(4'b0101, 32'h00A2_00A0, 1'b0);
    chk("sparse_no_early_out", 32'(out_vld_r), 0);
    expect_beat(32'hB3B1A2A0, 4'b1111, 1'b0);
    send(4'b1010, 32'hB300_B100, 1'b0);
    chk("sparse_latency_vld", 32'(out_vld_r), 1);
    chk("sparse_latency_last", 32'(out_last_r), 0);

    // Residual carry: 3 + 4 words gives one beat and 3 left over, then flushed.
    send(4'b0111, 32'h0012_1110, 1'b0);
    expect_beat(32'h20121110, 4'b1111, 1'b0);
    send(4'b1111, 32'h2322_2120, 1'b0);
    expect_beat(32'h00232221, 4'b0111, 1'b1);
    send(4'b0000, 32'h0, 1'b1);

    // Two-beat flush: in_rdy drops for exactly one cycle.
    send(4'b0111, 32'h0003_0201, 1'b0);
    expect_beat(32'h04030201, 4'b1111, 1'b0);
    expect_beat(32'h00070605, 4'b0111, 1'b1);
    send(4'b1111, 32'h0706_0504, 1'b1);
    chk("flush_in_rdy_low", 32'(in_rdy), 0);
    @(posedge clk); #1;
    chk("flush_in_rdy_back", 32'(in_rdy), 1);
    chk("flush_out_last", 32'(out_last_r), 1);

    // Empty frame end still emits a boundary beat.
    expect_beat(32'h0, 4'b0000, 1'b1);
    send(4'b0000, 32'h0, 1'b1);
    @(posedge clk); #1;

    // Backpressure: held beat stays stable, next beat accepted on release.
    out_rdy = 1'b0;
    expect_beat(32'h44434241, 4'b1111, 1'b0);
    send(4'b1111, 32'h4443_4241, 1'b0);
    in_vld = 1'b1; in_msk = 4'b1111; in_w = 32'h5453_5251; in_last = 1'b0;
    expect_beat(32'h54535251, 4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      chk("bp_in_rdy_low", 32'(in_rdy), 0);
      chk("bp_hold_data", 32'(out_r), 32'h44434241);
      chk("bp_hold_vld", 32'(out_vld_r), 1);
    end
    out_rdy = 1'b1;
    #1;
    chk("bp_release_in_rdy", 32'(in_rdy), 1);
    @(posedge clk); #1;
    in_vld = 1'b0; in_msk = '0; in_w = '0;
    chk("bp_no_bubble_vld", 32'(out_vld_r), 1);
    chk("bp_next_data", 32'(out_r), 32'h54535251);

    // Reset mid-frame discards the residual.
    send(4'b0011, 32'h0000_6261, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_vld", 32'(out_vld_r), 0);
    chk("midrst_out_msk", 32'(out_msk_r), 0);
    chk("midrst_in_rdy", 32'(in_rdy), 1);
    expect_beat(32'h94939291, 4'b1111, 1'b1);
    send(4'b1111, 32'h9493_9291, 1'b1);

    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_queue_empty", 32'(sb.size()), 0);
    chk("beat_count", 32'(n_pop), 32'(n_push));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
